// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-master arbiter for a single-ported data memory. Port 0 serves the CPU
// core, port 1 the debug/program-loader path. Each port uses a level req held
// until a one-cycle ack. Every access takes IDLE -> ACCESS -> ACK, so at most
// one memory access is in flight. Under contention, grants alternate through a
// 1-bit round-robin pointer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m0_* / m1_*         per-port req, we, addr, wdata in; rdata, ack out
//   MEM_ADDR, MEM_OUT   latched address / write data driven to the memory
//   MEM_CTRL            1 = write; high only during ACCESS of a write
//   MEM_IN              memory read data, valid combinationally in ACCESS
//   busy                high in any state other than IDLE
//   owner               port currently (or most recently) granted
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                rst,
  // port 0 (CPU)
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDRSIZE-1:0] m0_addr,
  input  logic [0:WIDTH-1]    m0_wdata,
  output logic [0:WIDTH-1]    m0_rdata,
  output logic                m0_ack,
  // port 1 (debug / loader)
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDRSIZE-1:0] m1_addr,
  input  logic [0:WIDTH-1]    m1_wdata,
  output logic [0:WIDTH-1]    m1_rdata,
  output logic                m1_ack,
  // memory side
  output logic [ADDRSIZE-1:0] MEM_ADDR,
  output logic [0:WIDTH-1]    MEM_OUT,
  output logic                MEM_CTRL,
  input  logic [0:WIDTH-1]    MEM_IN,
  // status
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e                state_q;
  logic                  last_q;      // round-robin pointer: last grantee
  logic                  owner_q;
  logic                  busy_q;
  logic                  we_q;
  logic                  mem_ctrl_q;
  logic [ADDRSIZE-1:0]   addr_q;
  logic [0:WIDTH-1]      wdata_q;
  logic [0:WIDTH-1]      m0_rdata_q;
  logic [0:WIDTH-1]      m1_rdata_q;
  logic                  m0_ack_q;
  logic                  m1_ack_q;

  // Grant decision for the IDLE sampling edge.
  logic                  grant_valid_d;
  logic                  grant_port_d;
  logic                  sel_we_d;
  logic [ADDRSIZE-1:0]   sel_addr_d;
  logic [0:WIDTH-1]      sel_wdata_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant_valid_d = m0_req | m1_req;
    grant_port_d  = 1'b0;
    if (m0_req && m1_req) begin
      grant_port_d = ~last_q;   // contention: the port that did not win last
    end else if (m1_req) begin
      grant_port_d = 1'b1;
    end

    sel_we_d    = grant_port_d ? m1_we    : m0_we;
    sel_addr_d  = grant_port_d ? m1_addr  : m0_addr;
    sel_wdata_d = grant_port_d ? m1_wdata : m0_wdata;
  end

  // Single FSM register block; all outputs come straight from flops so an
  // asynchronous reset clears MEM_CTRL and the acks immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;           // port 0 wins the first contention
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      mem_ctrl_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the ack defaults below are
      // overridden later in the same block, and the last write wins.
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            state_q    <= ACCESS;
            owner_q    <= grant_port_d;
            last_q     <= grant_port_d;
            addr_q     <= sel_addr_d;
            wdata_q    <= sel_wdata_d;
            we_q       <= sel_we_d;
            mem_ctrl_q <= sel_we_d;   // write strobe covers ACCESS only
            busy_q     <= 1'b1;
          end
        end

        ACCESS: begin
          mem_ctrl_q <= 1'b0;
          if (!we_q) begin
            if (owner_q) m1_rdata_q <= MEM_IN;
            else         m0_rdata_q <= MEM_IN;
          end
          if (owner_q) m1_ack_q <= 1'b1;
          else         m0_ack_q <= 1'b1;
          state_q <= ACK;
        end

        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          mem_ctrl_q <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_ADDR = addr_q;
  assign MEM_OUT  = wdata_q;
  assign MEM_CTRL = mem_ctrl_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A behavioural 4096 x 32 memory is
// attached to the memory pins (combinational read, write on a rising edge with
// MEM_CTRL high). Inputs are driven and outputs sampled 1 time unit after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int WIDTH    = 32;
  localparam int ADDRSIZE = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                m0_req, m0_we, m1_req, m1_we;
  logic [ADDRSIZE-1:0] m0_addr, m1_addr;
  logic [0:WIDTH-1]    m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic                m0_ack, m1_ack;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [0:WIDTH-1]    mem_out, mem_in;
  logic                mem_ctrl, busy, owner;

  logic [31:0] tb_mem [0:4095];

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m0_ack   (m0_ack),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .m1_ack   (m1_ack),
    .MEM_ADDR (mem_addr),
    .MEM_OUT  (mem_out),
    .MEM_CTRL (mem_ctrl),
    .MEM_IN   (mem_in),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  // Memory model.
  assign mem_in = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_ctrl) tb_mem[mem_addr] <= mem_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tb_mem[i] = 32'(i);
    tb_mem[12'h000] = 32'h0BAD_F00D;
    tb_mem[12'h001] = 32'hA5A5_0001;
    tb_mem[12'hFFF] = 32'hCAFE_F00D;

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    step();
    step();
    rst = 1'b0;

    // ---------------- reset state ----------------
    check("rst_owner",    32'(owner),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_m0_ack",   32'(m0_ack),   32'd0);
    check("rst_m1_ack",   32'(m1_ack),   32'd0);
    check("rst_m0_rdata", m0_rdata,      32'd0);
    check("rst_m1_rdata", m1_rdata,      32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_out",  mem_out,       32'd0);
    check("rst_mem_ctrl", 32'(mem_ctrl), 32'd0);

    // ---------------- port 0 write 0x00A ----------------
    m0_req = 1; m0_we = 1; m0_addr = 12'h00A; m0_wdata = 32'hDEADBEEF;
    step();  // grant edge
    check("wr_mem_ctrl", 32'(mem_ctrl), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'h00A);
    check("wr_mem_out",  mem_out,       32'hDEADBEEF);
    check("wr_busy",     32'(busy),     32'd1);
    check("wr_owner",    32'(owner),    32'd0);
    check("wr_ack_early",32'(m0_ack),   32'd0);
    m0_req = 0; m0_we = 0;
    step();  // ACK
    check("wr_ctrl_drop", 32'(mem_ctrl), 32'd0);
    check("wr_m0_ack",    32'(m0_ack),   32'd1);
    check("wr_m1_ack",    32'(m1_ack),   32'd0);
    step();  // IDLE
    check("wr_ack_end",   32'(m0_ack),   32'd0);
    check("wr_busy_end",  32'(busy),     32'd0);
    check("wr_addr_hold", 32'(mem_addr), 32'h00A);
    check("wr_mem_data",  tb_mem[12'h00A], 32'hDEADBEEF);

    // ---------------- port 0 read 0x00A ----------------
    m0_req = 1; m0_we = 0; m0_addr = 12'h00A;
    step();
    check("rd_mem_ctrl", 32'(mem_ctrl), 32'd0);
    check("rd_busy",     32'(busy),     32'd1);
    m0_req = 0;
    step();
    check("rd_m0_ack",   32'(m0_ack),   32'd1);
    check("rd_m0_rdata", m0_rdata,      32'hDEADBEEF);
    check("rd_m1_rdata", m1_rdata,      32'd0);
    step();
    check("rd_ack_end",  32'(m0_ack),   32'd0);

    // ---------------- asynchronous reset during ACCESS ----------------
    m1_req = 1; m1_we = 1; m1_addr = 12'h100; m1_wdata = 32'h12345678;
    step();
    check("ar_ctrl_before", 32'(mem_ctrl), 32'd1);
    check("ar_owner_before",32'(owner),    32'd1);
    m1_req = 0; m1_we = 0;
    #3 rst = 1'b1;
    #1;
    check("ar_mem_ctrl", 32'(mem_ctrl), 32'd0);
    check("ar_busy",     32'(busy),     32'd0);
    check("ar_owner",    32'(owner),    32'd0);
    check("ar_mem_addr", 32'(mem_addr), 32'd0);
    check("ar_m0_rdata", m0_rdata,      32'd0);
    step();
    rst = 1'b0;
    step();
    check("ar_no_ack",   32'(m1_ack),   32'd0);
    check("ar_idle",     32'(busy),     32'd0);
    check("ar_no_write", tb_mem[12'h100], 32'h0000_0100);

    // ---------------- contention from reset ----------------
    m0_req = 1; m0_we = 0; m0_addr = 12'h001;
    m1_req = 1; m1_we = 1; m1_addr = 12'h002; m1_wdata = 32'h22222222;
    step();
    check("ct_owner0",   32'(owner),    32'd0);
    check("ct_addr0",    32'(mem_addr), 32'h001);
    step();
    check("ct_m0_ack",   32'(m0_ack),   32'd1);
    check("ct_m1_ack0",  32'(m1_ack),   32'd0);
    check("ct_m0_rdata", m0_rdata,      32'hA5A50001);
    m0_req = 0;
    step();
    check("ct_idle",     32'(busy),     32'd0);
    step();
    check("ct_owner1",   32'(owner),    32'd1);
    check("ct_addr1",    32'(mem_addr), 32'h002);
    check("ct_out1",     mem_out,       32'h22222222);
    check("ct_ctrl1",    32'(mem_ctrl), 32'd1);
    m1_req = 0; m1_we = 0;
    step();
    check("ct_m1_ack",   32'(m1_ack),   32'd1);
    check("ct_m0_ack1",  32'(m0_ack),   32'd0);
    step();
    check("ct_mem2",     tb_mem[12'h002], 32'h22222222);

    // ---------------- sustained contention, 12 cycles ----------------
    m0_req = 1; m0_we = 0; m0_addr = 12'h00A;
    m1_req = 1; m1_we = 0; m1_addr = 12'h002;
    for (int k = 1; k <= 12; k++) begin
      int phase;
      logic g;
      step();
      phase = (k - 1) % 3;
      g     = 1'(((k - 1) / 3) % 2);
      check($sformatf("ss_owner_%0d", k), 32'(owner), 32'(g));
      check($sformatf("ss_busy_%0d", k),  32'(busy),  (phase == 2) ? 32'd0 : 32'd1);
      check($sformatf("ss_ack0_%0d", k),  32'(m0_ack), (phase == 1 && g == 1'b0) ? 32'd1 : 32'd0);
      check($sformatf("ss_ack1_%0d", k),  32'(m1_ack), (phase == 1 && g == 1'b1) ? 32'd1 : 32'd0);
      if (phase == 1) begin
        if (g == 1'b0) check($sformatf("ss_rd0_%0d", k), m0_rdata, 32'hDEADBEEF);
        else           check($sformatf("ss_rd1_%0d", k), m1_rdata, 32'h22222222);
      end
    end
    m0_req = 0; m1_req = 0;
    step();
    check("ss_quiet", 32'(busy), 32'd0);

    // ---------------- request withdrawal on port 1 ----------------
    m1_req = 1; m1_we = 1; m1_addr = 12'h003; m1_wdata = 32'h33333333;
    step();
    check("wd_owner", 32'(owner),    32'd1);
    check("wd_addr",  32'(mem_addr), 32'h003);
    check("wd_out",   mem_out,       32'h33333333);
    m1_req = 0; m1_we = 0; m1_addr = 12'hFFF; m1_wdata = '0;
    step();
    check("wd_ack",       32'(m1_ack),   32'd1);
    check("wd_addr_hold", 32'(mem_addr), 32'h003);
    check("wd_rdata",     m1_rdata,      32'h22222222);
    step();
    check("wd_mem3",   tb_mem[12'h003], 32'h33333333);
    check("wd_memfff", tb_mem[12'hFFF], 32'hCAFEF00D);

    // ---------------- address boundary on port 1 ----------------
    m1_req = 1; m1_we = 0; m1_addr = 12'hFFF;
    step();
    check("ab_addr_fff", 32'(mem_addr), 32'hFFF);
    m1_req = 0;
    step();
    check("ab_ack_fff",  32'(m1_ack),   32'd1);
    check("ab_rd_fff",   m1_rdata,      32'hCAFEF00D);
    step();
    m1_req = 1; m1_addr = 12'h000;
    step();
    check("ab_addr_000", 32'(mem_addr), 32'h000);
    m1_req = 0;
    step();
    check("ab_ack_000",  32'(m1_ack),   32'd1);
    check("ab_rd_000",   m1_rdata,      32'h0BADF00D);
    check("ab_m0_hold",  m0_rdata,      32'hDEADBEEF);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
